hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Purpose : shared types and helpers for the decode hazard scoreboard.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  // Entries store rd zero-extended to this width. Comparing two zero-extended
  // identifiers is the same as a full REG_W equality. REG_W must not exceed it.
  localparam int RD_MAX_W = 8;

  // Forward select value meaning "read the register file".
  localparam int FWD_NONE = 0;

  // One in-flight instruction downstream of decode.
  typedef struct packed {
    logic                v;   // entry holds a real register write
    logic [RD_MAX_W-1:0] rd;  // destination identifier
    logic                ld;  // result only exists at the end of MEM
  } sb_entry_t;

  // Width of a forward select: 0 = register file, 1..depth = entry index + 1.
  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Purpose : decode <-> hazard unit bundle (register ids, flush/freeze in; stall/forward out).
// Latency : n/a (wires only).
// Backpressure: stall is the backpressure towards fetch/decode; freeze holds the whole pipe.
// Ports   : master = decode side (drives ids/valids/flush/freeze), slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 3,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  import hazard_scoreboard_pkg::*;

  localparam int FWD_W = fwd_w(DEPTH);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic             id_rs_valid;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_valid;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_valid;
  logic             id_is_load;
  logic             flush;
  logic             freeze;
  logic             stall;
  logic [FWD_W-1:0] fwd_rs;
  logic [FWD_W-1:0] fwd_rt;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rs_valid, id_rt, id_rt_valid,
           id_rd, id_rd_valid, id_is_load, flush, freeze,
    input  stall, fwd_rs, fwd_rt, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_valid, id_rt, id_rt_valid,
           id_rd, id_rd_valid, id_is_load, flush, freeze,
    output stall, fwd_rs, fwd_rt, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Purpose : youngest-entry RAW match finder for one source operand.
// Latency : combinational, zero cycles.
// Backpressure: none; pure lookup.
// Ports   : entries (scoreboard), id_valid/src/src_valid in; hit, idx (entry k), ld out.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  localparam int FWD_W    = fwd_w(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      src,
  input  logic                  src_valid,
  output logic                  hit,
  output logic [FWD_W-1:0]      idx,
  output logic                  ld
);

  // Walk from oldest to youngest so the youngest match overwrites the rest.
  // With WB_BYPASS the register file already holds the WB value, so the last
  // entry is masked out rather than skipped (keeps every entry bit in use).
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ld  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_valid && src_valid && entries[k].v &&
          entries[k].rd == RD_MAX_W'(src) &&
          !(WB_BYPASS != 0 && k == DEPTH - 1)) begin
        hit = 1'b1;
        idx = FWD_W'(k);
        ld  = entries[k].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : decode hazard unit - scoreboard of in-flight writers, stall and forward selects.
// Latency : stall/fwd combinational from decode inputs; scoreboard advances one stage per clock.
// Backpressure: raises stall on a hazard (bubble inserted); freeze holds all state.
// Ports   : clk, rst_n (async, active-low), sb = hazard_scoreboard_if.slave.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int DEPTH     = 3,
  parameter int FORWARD   = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  localparam int FWD_W = fwd_w(DEPTH);

  sb_entry_t [DEPTH-1:0] entries;
  logic [CNT_W-1:0]      cnt;

  logic             hit_rs, hit_rt;
  logic             ld_rs, ld_rt;
  logic [FWD_W-1:0] idx_rs, idx_rt;
  logic             raw_hz;

  hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .WB_BYPASS(WB_BYPASS)) u_match_rs (
    .entries   (entries),
    .id_valid  (sb.id_valid),
    .src       (sb.id_rs),
    .src_valid (sb.id_rs_valid),
    .hit       (hit_rs),
    .idx       (idx_rs),
    .ld        (ld_rs)
  );

  hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .WB_BYPASS(WB_BYPASS)) u_match_rt (
    .entries   (entries),
    .id_valid  (sb.id_valid),
    .src       (sb.id_rt),
    .src_valid (sb.id_rt_valid),
    .hit       (hit_rt),
    .idx       (idx_rt),
    .ld        (ld_rt)
  );

  // With a bypass network only a load directly ahead (in EX) cannot be
  // forwarded in time; everything else is served by the forward select.
  always_comb begin
    raw_hz    = 1'b0;
    sb.fwd_rs = FWD_W'(FWD_NONE);
    sb.fwd_rt = FWD_W'(FWD_NONE);
    if (FORWARD != 0) begin
      raw_hz = (hit_rs && idx_rs == '0 && ld_rs) ||
               (hit_rt && idx_rt == '0 && ld_rt);
      if (hit_rs) sb.fwd_rs = FWD_W'(idx_rs + FWD_W'(1));
      if (hit_rt) sb.fwd_rt = FWD_W'(idx_rt + FWD_W'(1));
    end else begin
      raw_hz = hit_rs || hit_rt;
    end
  end

  // Flush removes the instruction that would have stalled; freeze wins over all.
  assign sb.stall       = (raw_hz && !sb.flush) || sb.freeze;
  assign sb.stall_count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
      cnt     <= '0;
    end else if (!sb.freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      // Bubble on hazard, flush or empty decode slot.
      entries[0].v  <= sb.id_valid && sb.id_rd_valid && !sb.flush && !raw_hz;
      entries[0].rd <= RD_MAX_W'(sb.id_rd);
      entries[0].ld <= sb.id_is_load;
      if (raw_hz && !sb.flush && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int REG_W   = 3;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 4;
  localparam int FWD_W   = fwd_w(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, in_rsv, in_rtv, in_rdv, in_ld, in_flush, in_freeze;
  logic [REG_W-1:0] in_rs, in_rt, in_rd;

  hazard_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) ifc_f ();
  hazard_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) ifc_n ();

  assign ifc_f.id_valid = in_valid;   assign ifc_n.id_valid = in_valid;
  assign ifc_f.id_rs = in_rs;         assign ifc_n.id_rs = in_rs;
  assign ifc_f.id_rs_valid = in_rsv;  assign ifc_n.id_rs_valid = in_rsv;
  assign ifc_f.id_rt = in_rt;         assign ifc_n.id_rt = in_rt;
  assign ifc_f.id_rt_valid = in_rtv;  assign ifc_n.id_rt_valid = in_rtv;
  assign ifc_f.id_rd = in_rd;         assign ifc_n.id_rd = in_rd;
  assign ifc_f.id_rd_valid = in_rdv;  assign ifc_n.id_rd_valid = in_rdv;
  assign ifc_f.id_is_load = in_ld;    assign ifc_n.id_is_load = in_ld;
  assign ifc_f.flush = in_flush;      assign ifc_n.flush = in_flush;
  assign ifc_f.freeze = in_freeze;    assign ifc_n.freeze = in_freeze;

  // Forwarding core and non-forwarding core, same stimulus.
  hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .FORWARD(1), .WB_BYPASS(1), .CNT_W(CNT_W)) dut_f (
    .clk(clk), .rst_n(rst_n), .sb(ifc_f));
  hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .FORWARD(0), .WB_BYPASS(1), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .rst_n(rst_n), .sb(ifc_n));

  int total = 0;
  int bad   = 0;

  task automatic drive(input bit v, input int rs, input bit rsv, input int rt, input bit rtv,
                       input int rd, input bit rdv, input bit ld, input bit fl, input bit fr);
    in_valid = v;  in_rs = REG_W'(rs); in_rsv = rsv; in_rt = REG_W'(rt); in_rtv = rtv;
    in_rd = REG_W'(rd); in_rdv = rdv; in_ld = ld; in_flush = fl; in_freeze = fr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL reset_stall_f got=%b want=0", ifc_f.stall); end
    total++; if (ifc_f.fwd_rs !== 2'd0) begin bad++; $display("FAIL reset_fwd_rs got=%0d want=0", ifc_f.fwd_rs); end
    total++; if (ifc_f.fwd_rt !== 2'd0) begin bad++; $display("FAIL reset_fwd_rt got=%0d want=0", ifc_f.fwd_rt); end
    total++; if (ifc_f.stall_count !== 4'd0) begin bad++; $display("FAIL reset_cnt_f got=%0d want=0", ifc_f.stall_count); end
    total++; if (ifc_n.stall_count !== 4'd0) begin bad++; $display("FAIL reset_cnt_n got=%0d want=0", ifc_n.stall_count); end
    step();
    rst_n = 1'b1;
    step();
    // Idle decode after reset reads R0..: nothing in flight, so no stall.
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    #2;
    total++; if (ifc_n.stall !== 1'b0) begin bad++; $display("FAIL idle_stall_n got=%b want=0", ifc_n.stall); end
    total++; if (ifc_f.fwd_rs !== 2'd0) begin bad++; $display("FAIL idle_fwd_rs got=%0d want=0", ifc_f.fwd_rs); end
    step();
  endtask

  task automatic test_fwd_alu();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);           // ADD R3
    #2;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL alu_add_stall got=%b want=0", ifc_f.stall); end
    step();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);           // SUB R4 <- R3
    #2;
    total++; if (ifc_f.fwd_rs !== 2'd1) begin bad++; $display("FAIL alu_fwd1 got=%0d want=1", ifc_f.fwd_rs); end
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL alu_nostall got=%b want=0", ifc_f.stall); end
    total++; if (ifc_n.stall !== 1'b1) begin bad++; $display("FAIL alu_n_stall got=%b want=1", ifc_n.stall); end
    step();
    drive(1, 3, 1, 0, 0, 5, 1, 0, 0, 0);           // reader of R3 one cycle later
    #2;
    total++; if (ifc_f.fwd_rs !== 2'd2) begin bad++; $display("FAIL alu_fwd2 got=%0d want=2", ifc_f.fwd_rs); end
    total++; if (ifc_f.fwd_rt !== 2'd0) begin bad++; $display("FAIL alu_fwd_rt got=%0d want=0", ifc_f.fwd_rt); end
    total++; if (ifc_n.stall !== 1'b1) begin bad++; $display("FAIL alu_n_stall2 got=%b want=1", ifc_n.stall); end
    total++; if (ifc_n.fwd_rs !== 2'd0) begin bad++; $display("FAIL alu_n_fwd got=%0d want=0", ifc_n.fwd_rs); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);           // LD R2
    step();
    drive(1, 0, 0, 2, 1, 7, 1, 0, 0, 0);           // ADD R7 <- R2 (rt)
    #2;
    total++; if (ifc_f.stall !== 1'b1) begin bad++; $display("FAIL ldu_stall got=%b want=1", ifc_f.stall); end
    total++; if (ifc_f.fwd_rt !== 2'd1) begin bad++; $display("FAIL ldu_fwd1 got=%0d want=1", ifc_f.fwd_rt); end
    step();
    #2;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL ldu_release got=%b want=0", ifc_f.stall); end
    total++; if (ifc_f.fwd_rt !== 2'd2) begin bad++; $display("FAIL ldu_fwd2 got=%0d want=2", ifc_f.fwd_rt); end
    total++; if (ifc_f.stall_count !== 4'd1) begin bad++; $display("FAIL ldu_cnt got=%0d want=1", ifc_f.stall_count); end
    total++; if (ifc_n.stall !== 1'b1) begin bad++; $display("FAIL ldu_n_stall got=%b want=1", ifc_n.stall); end
    step();
    idle();
    #2;
    total++; if (ifc_f.stall_count !== 4'd1) begin bad++; $display("FAIL ldu_cnt_hold got=%0d want=1", ifc_f.stall_count); end
    total++; if (ifc_n.stall_count !== 4'd2) begin bad++; $display("FAIL ldu_n_cnt got=%0d want=2", ifc_n.stall_count); end
    step();
  endtask

  task automatic test_nofwd();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);           // write R5
    step();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);           // R6 <- R5
    for (int c = 0; c < 3; c++) begin
      #2;
      total++; if (ifc_n.stall !== (c < 2)) begin bad++; $display("FAIL nofwd_stall c=%0d got=%b want=%b", c, ifc_n.stall, (c < 2)); end
      step();
    end
    idle();
    #2;
    total++; if (ifc_n.stall_count !== 4'd2) begin bad++; $display("FAIL nofwd_cnt got=%0d want=2", ifc_n.stall_count); end
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);           // reader of R6 proves it issued
    #1;
    total++; if (ifc_n.stall !== 1'b1) begin bad++; $display("FAIL nofwd_issued got=%b want=1", ifc_n.stall); end
    total++; if (ifc_f.fwd_rs !== 2'd1) begin bad++; $display("FAIL nofwd_f_fwd got=%0d want=1", ifc_f.fwd_rs); end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);           // LD R1
    step();
    drive(1, 1, 1, 0, 0, 3, 1, 0, 1, 0);           // flushed user of R1, writes R3
    #2;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL flush_stall_f got=%b want=0", ifc_f.stall); end
    total++; if (ifc_n.stall !== 1'b0) begin bad++; $display("FAIL flush_stall_n got=%b want=0", ifc_n.stall); end
    step();
    drive(1, 1, 1, 3, 1, 4, 1, 0, 0, 0);
    #2;
    total++; if (ifc_f.fwd_rs !== 2'd2) begin bad++; $display("FAIL flush_bubble got=%0d want=2", ifc_f.fwd_rs); end
    total++; if (ifc_f.fwd_rt !== 2'd0) begin bad++; $display("FAIL flush_nowrite got=%0d want=0", ifc_f.fwd_rt); end
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL flush_ld_k1 got=%b want=0", ifc_f.stall); end
    total++; if (ifc_f.stall_count !== 4'd0) begin bad++; $display("FAIL flush_cnt got=%0d want=0", ifc_f.stall_count); end
    step();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);           // LD R1
    step();
    drive(1, 1, 1, 0, 0, 2, 1, 0, 0, 1);           // user of R1 under freeze
    step();
    #2;
    total++; if (ifc_f.stall !== 1'b1) begin bad++; $display("FAIL frz_stall got=%b want=1", ifc_f.stall); end
    total++; if (ifc_f.fwd_rs !== 2'd1) begin bad++; $display("FAIL frz_hold got=%0d want=1", ifc_f.fwd_rs); end
    total++; if (ifc_f.stall_count !== 4'd0) begin bad++; $display("FAIL frz_cnt_f got=%0d want=0", ifc_f.stall_count); end
    total++; if (ifc_n.stall_count !== 4'd0) begin bad++; $display("FAIL frz_cnt_n got=%0d want=0", ifc_n.stall_count); end
    step();
    in_freeze = 1'b0;
    #2;
    total++; if (ifc_f.stall !== 1'b1) begin bad++; $display("FAIL frz_ldu got=%b want=1", ifc_f.stall); end
    step();
    #2;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL frz_release got=%b want=0", ifc_f.stall); end
    total++; if (ifc_f.fwd_rs !== 2'd2) begin bad++; $display("FAIL frz_fwd2 got=%0d want=2", ifc_f.fwd_rs); end
    total++; if (ifc_f.stall_count !== 4'd1) begin bad++; $display("FAIL frz_cnt_after got=%0d want=1", ifc_f.stall_count); end
    total++; if (ifc_n.stall_count !== 4'd1) begin bad++; $display("FAIL frz_n_cnt got=%0d want=1", ifc_n.stall_count); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      int want;
      want = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
      drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);         // LD R6
      step();
      drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);         // load-use, one stall on both cores
      step();
      total++; if (ifc_f.stall_count !== CNT_W'(want)) begin bad++; $display("FAIL sat_f i=%0d got=%0d want=%0d", i, ifc_f.stall_count, want); end
      total++; if (ifc_n.stall_count !== CNT_W'(want)) begin bad++; $display("FAIL sat_n i=%0d got=%0d want=%0d", i, ifc_n.stall_count, want); end
    end
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    step();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    total++; if (ifc_f.stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b want=1", ifc_f.stall); end
    rst_n = 1'b0;
    #1;
    total++; if (ifc_f.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", ifc_f.stall); end
    total++; if (ifc_f.stall_count !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt_f got=%0d want=0", ifc_f.stall_count); end
    total++; if (ifc_n.stall_count !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt_n got=%0d want=0", ifc_n.stall_count); end
    idle();
    step();
    rst_n = 1'b1;
  endtask

  // Reference model: list of in-flight writers per core, youngest first.
  bit mv [2][DEPTH];
  int mrd[2][DEPTH];
  bit mld[2][DEPTH];
  int mcnt[2];

  function automatic int youngest(input int m, input int s, input bit sv);
    // The last stage writes the register file before decode reads it.
    for (int k = 0; k < DEPTH - 1; k++)
      if (in_valid && sv && mv[m][k] && mrd[m][k] == s) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      for (int k = 0; k < DEPTH; k++) begin mv[m][k] = 0; mrd[m][k] = 0; mld[m][k] = 0; end
    end
  endtask

  task automatic test_random();
    do_reset();
    model_clear();
    for (int c = 0; c < 400; c++) begin
      bit hz[2]; bit est[2]; int efr[2]; int eft[2];
      if (c == 200) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_clear();
      end
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      #2;
      for (int m = 0; m < 2; m++) begin
        int ks, kt;
        ks = youngest(m, int'(in_rs), in_rsv);
        kt = youngest(m, int'(in_rt), in_rtv);
        if (m == 0) begin
          hz[m]  = (ks == 0 && mld[m][0]) || (kt == 0 && mld[m][0]);
          efr[m] = ks + 1;
          eft[m] = kt + 1;
        end else begin
          hz[m]  = (ks >= 0) || (kt >= 0);
          efr[m] = 0;
          eft[m] = 0;
        end
        est[m] = (hz[m] && !in_flush) || in_freeze;
      end
      total++; if (ifc_f.stall !== est[0]) begin bad++; $display("FAIL rnd_stall_f c=%0d got=%b want=%b", c, ifc_f.stall, est[0]); end
      total++; if (ifc_f.fwd_rs !== FWD_W'(efr[0])) begin bad++; $display("FAIL rnd_fwd_rs c=%0d got=%0d want=%0d", c, ifc_f.fwd_rs, efr[0]); end
      total++; if (ifc_f.fwd_rt !== FWD_W'(eft[0])) begin bad++; $display("FAIL rnd_fwd_rt c=%0d got=%0d want=%0d", c, ifc_f.fwd_rt, eft[0]); end
      total++; if (ifc_f.stall_count !== CNT_W'(mcnt[0])) begin bad++; $display("FAIL rnd_cnt_f c=%0d got=%0d want=%0d", c, ifc_f.stall_count, mcnt[0]); end
      total++; if (ifc_n.stall !== est[1]) begin bad++; $display("FAIL rnd_stall_n c=%0d got=%b want=%b", c, ifc_n.stall, est[1]); end
      total++; if (ifc_n.fwd_rs !== FWD_W'(efr[1]) || ifc_n.fwd_rt !== FWD_W'(eft[1])) begin bad++; $display("FAIL rnd_fwd_n c=%0d got=%0d/%0d want=0/0", c, ifc_n.fwd_rs, ifc_n.fwd_rt); end
      total++; if (ifc_n.stall_count !== CNT_W'(mcnt[1])) begin bad++; $display("FAIL rnd_cnt_n c=%0d got=%0d want=%0d", c, ifc_n.stall_count, mcnt[1]); end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!in_freeze) begin
          for (int k = DEPTH - 1; k > 0; k--) begin
            mv[m][k] = mv[m][k-1]; mrd[m][k] = mrd[m][k-1]; mld[m][k] = mld[m][k-1];
          end
          mv[m][0]  = in_valid && in_rdv && !in_flush && !hz[m];
          mrd[m][0] = int'(in_rd);
          mld[m][0] = in_ld;
          if (hz[m] && !in_flush && mcnt[m] < CNT_MAX) mcnt[m]++;
        end
      end
      #1;
    end
    idle();
  endtask

  initial begin
    idle();
    #6;
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_nofwd();
    test_flush();
    test_freeze();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
